id_ex_register: RTL

ID_EX_REGISTER -- requirements
Module: id_ex_register

---
 rtl/id_ex_register.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with Hold/Flush control and optional load-use detection.
// Define HAZARD_DETECT_EN to enable load-use stall generation and bubble insertion.
module id_ex_register #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RegDst,
    input  logic              ALUSrc,
    input  logic              MemtoReg,
    input  logic              RegWrite,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              Branch,
    input  logic              Jump,
    input  logic              JAL,
    input  logic [1:0]        ALUOp,
    input  logic [DATA_W-1:0] ReadData1,
    input  logic [DATA_W-1:0] ReadData2,
    input  logic [DATA_W-1:0] SignExtImm,
    input  logic [DATA_W-1:0] PCPlus4,
    input  logic [4:0]        Rs,
    input  logic [4:0]        Rt,
    input  logic [4:0]        Rd,
    input  logic [5:0]        Funct,
    input  logic              Flush,
    input  logic              Hold,
    output logic              EX_RegDst,
    output logic              EX_ALUSrc,
    output logic              EX_MemtoReg,
    output logic              EX_RegWrite,
    output logic              EX_MemRead,
    output logic              EX_MemWrite,
    output logic              EX_Branch,
    output logic              EX_Jump,
    output logic              EX_JAL,
    output logic [1:0]        EX_ALUOp,
    output logic [DATA_W-1:0] EX_ReadData1,
    output logic [DATA_W-1:0] EX_ReadData2,
    output logic [DATA_W-1:0] EX_SignExtImm,
    output logic [DATA_W-1:0] EX_PCPlus4,
    output logic [4:0]        EX_Rs,
    output logic [4:0]        EX_Rt,
    output logic [4:0]        EX_Rd,
    output logic [5:0]        EX_Funct,
    output logic              EX_Valid,
    output logic              LoadUseStall
);

    typedef struct packed {
        logic              reg_dst;
        logic              alu_src;
        logic              mem_to_reg;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              branch;
        logic              jump;
        logic              jal;
        logic [1:0]        alu_op;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc4;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [5:0]        funct;
    } id_ex_t;

    id_ex_t r_ex;
    logic   r_valid;
    id_ex_t w_id;
    logic   w_hazard;
    logic   w_bubble;

    assign w_id = '{
        reg_dst:    RegDst,
        alu_src:    ALUSrc,
        mem_to_reg: MemtoReg,
        reg_write:  RegWrite,
        mem_read:   MemRead,
        mem_write:  MemWrite,
        branch:     Branch,
        jump:       Jump,
        jal:        JAL,
        alu_op:     ALUOp,
        rd1:        ReadData1,
        rd2:        ReadData2,
        imm:        SignExtImm,
        pc4:        PCPlus4,
        rs:         Rs,
        rt:         Rt,
        rd:         Rd,
        funct:      Funct
    };

`ifdef HAZARD_DETECT_EN
    // Rt of the consumer only matters when it is actually read as a source.
    assign w_hazard = r_valid && r_ex.mem_read && (r_ex.rt != 5'd0) &&
                      ((r_ex.rt == Rs) ||
                       ((r_ex.rt == Rt) && (RegDst || Branch || MemWrite)));
`else
    assign w_hazard = 1'b0;
`endif

    assign LoadUseStall = w_hazard && !Flush && !Hold;
    assign w_bubble     = Flush || LoadUseStall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex    <= '0;
            r_valid <= 1'b0;
        end else if (!Hold) begin
            if (w_bubble) begin
                r_ex    <= '0;
                r_valid <= 1'b0;
            end else begin
                r_ex    <= w_id;
                r_valid <= 1'b1;
            end
        end
    end

    assign EX_RegDst     = r_ex.reg_dst;
    assign EX_ALUSrc     = r_ex.alu_src;
    assign EX_MemtoReg   = r_ex.mem_to_reg;
    assign EX_RegWrite   = r_ex.reg_write;
    assign EX_MemRead    = r_ex.mem_read;
    assign EX_MemWrite   = r_ex.mem_write;
    assign EX_Branch     = r_ex.branch;
    assign EX_Jump       = r_ex.jump;
    assign EX_JAL        = r_ex.jal;
    assign EX_ALUOp      = r_ex.alu_op;
    assign EX_ReadData1  = r_ex.rd1;
    assign EX_ReadData2  = r_ex.rd2;
    assign EX_SignExtImm = r_ex.imm;
    assign EX_PCPlus4    = r_ex.pc4;
    assign EX_Rs         = r_ex.rs;
    assign EX_Rt         = r_ex.rt;
    assign EX_Rd         = r_ex.rd;
    assign EX_Funct      = r_ex.funct;
    assign EX_Valid      = r_valid;

endmodule
